fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch front end: drives the fetch address into the combinational instruction memory and collects the returned 32-bit words into a small in-order buffer. Presents `{pc, instr}` pairs to decode over a valid/ready handshake. Accepts redirects (branches, jumps) that reload the PC and flush buffered instructions. Sits between the instruction memory and the decode stage of the mini CPU.

## Interface

Parameters:
- `RESET_PC`, 64'h0, PC loaded on reset.
- `PC_STEP`, 8, sequential PC increment in bytes. Matches the memory's 8-byte-aligned word addressing (`pc[9:3]`).
- `DEPTH`, 2, instruction buffer entries. Power of two, ≥ 2.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `pc`  out  64  fetch address to instruction memory.
- `instr`  in  32  instruction word from memory, combinational from `pc`.
- `out_valid`  out  1  buffer head is valid.
- `out_ready`  in  1  decode accepts the head this cycle.
- `out_instr`  out  32  head instruction.
- `out_pc`  out  64  PC of the head instruction.
- `redirect`  in  1  load `redirect_pc` and flush the buffer.
- `redirect_pc`  in  64  redirect target.
- `misaligned`  out  1  sticky misaligned-redirect trap (see Configuration).

## Operation

- State:
  - `pc_q`, 64 bits; drives `pc`.
  - Circular buffer of `DEPTH` entries, each `{pc[63:0], instr[31:0]}`.
  - Read and write pointers, `log2(DEPTH)` bits, wrapping modulo `DEPTH`.
  - `count`, `log2(DEPTH)+1` bits.
  - `misaligned` flag.
- `deq = out_valid & out_ready`.
- `enq = !redirect & !misaligned & (count < DEPTH | deq)`.
  - Full buffer with a simultaneous dequeue still enqueues.
- On `enq`:
  - Write `{pc_q, instr}` at the write pointer.
  - Advance the write pointer.
  - `pc_q <= pc_q + PC_STEP`, modulo 2^64; wraps silently.
- On `deq`: advance the read pointer.
- `count` is updated by +1, −1 or 0 from `enq` and `deq`.
- `out_valid = (count != 0)`. `out_instr`/`out_pc` are read combinationally from the head entry. Their value is don't-care when `out_valid` is 0.
- Redirect has priority over all else:
  - `pc_q <= redirect_pc`.
  - Pointers and `count` are cleared.
  - No enqueue occurs that cycle.
  - A `deq` in the same cycle still completes: decode owns that instruction. The remaining entries are discarded.
- Reset, including mid-operation:
  - `pc_q = RESET_PC`; pointers and `count` cleared; `misaligned = 0`.
  - Outputs after reset: `pc = RESET_PC`, `out_valid = 0`, `misaligned = 0`.
  - Buffer contents need not be cleared.
- Decode stalled (`out_ready = 0`): buffer fills to `DEPTH`. `pc_q` then holds at the next unfetched address.

## Timing

- Memory read is combinational within the cycle. Capture happens at the rising edge.
- First `out_valid = 1`: the first edge after reset deasserts. `out_pc = RESET_PC` at that point.
- Throughput: one instruction per cycle while decode holds `out_ready = 1`.
- Redirect asserted in cycle N:
  - `pc = redirect_pc` in cycle N+1.
  - `out_valid = 0` in N+1.
  - Target instruction valid at the head in N+2.
- Redirect held for k cycles: fetch is suppressed for all k cycles. The last `redirect_pc` wins.
- `out_valid` is not a function of `out_ready` in the same cycle. No combinational path from `out_ready` to `out_valid`.

## Configuration

`FETCH_MISALIGN_TRAP_EN`:
- Defined:
  - A redirect with `redirect_pc % PC_STEP != 0` sets `misaligned` on the next edge.
  - `pc_q` loads the raw target.
  - Enqueue stops until reset. Already-delivered instructions are unaffected.
  - Later redirects do not clear the flag.
- Undefined:
  - `misaligned` is tied to 0.
  - The redirect target is rounded down to a multiple of `PC_STEP` before loading `pc_q`.

## Test plan

- **Reset/sequential fetch:** memory holds 0x11,0x22,0x33 at 0,8,16; `out_ready = 1`.
  - Required: `pc` = 0, 8, 16; `out_pc`/`out_instr` = 0/0x11, 8/0x22, 16/0x33 on consecutive cycles from the first post-reset edge.
- **Backpressure:** `out_ready = 0` for 5 cycles, then 1.
  - Required: `count` saturates at 2; `pc` holds at 16; head stays 0/0x11.
  - After release, all instructions are delivered in order with no gap.
- **Redirect with simultaneous dequeue:** buffer full, `redirect = 1`, `redirect_pc = 0x40`, `out_ready = 1`.
  - Required: the head instruction is consumed and the other entry is dropped.
  - `pc = 0x40` next cycle with `out_valid = 0`; `out_pc = 0x40` the cycle after.
- **Reset mid-stream:** assert `rst` asynchronously between edges with 2 entries buffered.
  - Required: `out_valid` goes to 0 and `pc` goes to `RESET_PC` immediately, with no clock edge.
- **Misaligned redirect:** `redirect_pc = 0x44`.
  - With the macro defined: `misaligned = 1` and no further `out_valid`.
  - Without it: `pc = 0x40` and normal fetch continues.
- **PC wrap:** `redirect_pc = 64'hFFFF_FFFF_FFFF_FFF8`.
  - Required: the next fetch address is 0; both instructions are delivered in order.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC generation plus an in-order {pc, instr} buffer.
// Optional FETCH_MISALIGN_TRAP_EN: trap on misaligned redirect instead of rounding.
module fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int unsigned PC_STEP  = 8,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [63:0] pc,
  input  logic [31:0] instr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [63:0] out_pc,
  input  logic        redirect,
  input  logic [63:0] redirect_pc,
  output logic        misaligned
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [63:0] STEP = 64'(PC_STEP);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [63:0]   pc_q, pc_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [63:0]   buf_pc_q [DEPTH];
  logic [31:0]   buf_in_q [DEPTH];

  logic [63:0] rem;
  logic [63:0] tgt;
  logic        enq;
  logic        deq;

  assign rem = redirect_pc % STEP;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic mis_q;

  assign tgt        = redirect_pc;
  assign misaligned = mis_q;

  // Sticky until reset; later redirects cannot clear it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mis_q <= 1'b0;
    end else if (redirect && rem != 64'd0) begin
      mis_q <= 1'b1;
    end
  end
`else
  assign tgt        = redirect_pc - rem;
  assign misaligned = 1'b0;
`endif

  assign pc        = pc_q;
  assign out_valid = (cnt_q != '0);
  assign out_pc    = buf_pc_q[rptr_q];
  assign out_instr = buf_in_q[rptr_q];

  assign deq = out_valid & out_ready;
  assign enq = ~redirect & ~misaligned & ((cnt_q < FULL) | deq);

  always_comb begin
    pc_d   = pc_q;
    rptr_d = rptr_q;
    wptr_d = wptr_q;
    cnt_d  = cnt_q;
    if (redirect) begin
      pc_d   = tgt;
      rptr_d = '0;
      wptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (enq) begin
        pc_d   = pc_q + STEP;
        wptr_d = wptr_q + AW'(1);
      end
      if (deq) begin
        rptr_d = rptr_q + AW'(1);
      end
      unique case ({enq, deq})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q   <= RESET_PC;
      rptr_q <= '0;
      wptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      pc_q   <= pc_d;
      rptr_q <= rptr_d;
      wptr_q <= wptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Payload storage needs no reset; count gates visibility.
  always_ff @(posedge clk) begin
    if (enq) begin
      buf_pc_q[wptr_q] <= pc_q;
      buf_in_q[wptr_q] <= instr;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random traffic
// checked cycle by cycle against a queue-based reference model.
module tb_fetch_unit;

  localparam logic [63:0] RESET_PC = 64'h0;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] pc;
  logic [31:0] instr;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [63:0] out_pc;
  logic        redirect = 1'b0;
  logic [63:0] redirect_pc = 64'h0;
  logic        misaligned;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] ins;
  } ent_t;

  ent_t        q[$];
  logic [63:0] m_pc;
  logic        m_mis;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    logic [31:0] h;
    if (a == 64'd0) return 32'h11;
    if (a == 64'd8) return 32'h22;
    if (a == 64'd16) return 32'h33;
    h = a[34:3] * 32'h9E37_79B1;
    return h ^ a[63:32];
  endfunction

  assign instr = mem_word(pc);

  fetch_unit #(
    .RESET_PC(RESET_PC),
    .PC_STEP (8),
    .DEPTH   (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pc         (pc),
    .instr      (instr),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_instr  (out_instr),
    .out_pc     (out_pc),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .misaligned (misaligned)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_all(input string tag);
    chk({tag, ".valid"}, 64'(out_valid), 64'(q.size() != 0));
    if (q.size() != 0) begin
      chk({tag, ".out_pc"}, out_pc, q[0].pc);
      chk({tag, ".out_instr"}, 64'(out_instr), 64'(q[0].ins));
    end
    chk({tag, ".pc"}, pc, m_pc);
    chk({tag, ".mis"}, 64'(misaligned), 64'(m_mis));
  endtask

  // Reference behaviour for one rising edge with the given inputs.
  task automatic model_edge(input logic rdy, input logic red,
                            input logic [63:0] rpc);
    logic take;
    take = (q.size() != 0) && rdy;
    if (red) begin
      q.delete();
`ifdef FETCH_MISALIGN_TRAP_EN
      m_pc = rpc;
      if (rpc % 8 != 0) m_mis = 1'b1;
`else
      m_pc = rpc - (rpc % 8);
`endif
    end else begin
      if (take) void'(q.pop_front());
      if (!m_mis && q.size() < DEPTH) begin
        q.push_back('{pc: m_pc, ins: mem_word(m_pc)});
        m_pc = m_pc + 64'd8;
      end
    end
  endtask

  // Called at a falling edge: drive, clock once, compare at next fall.
  task automatic step(input string tag, input logic rdy, input logic red,
                      input logic [63:0] rpc);
    out_ready   = rdy;
    redirect    = red;
    redirect_pc = rpc;
    @(posedge clk);
    model_edge(rdy, red, rpc);
    @(negedge clk);
    compare_all(tag);
  endtask

  // Asynchronous reset asserted between edges.
  task automatic do_reset(input string tag);
    #2;
    out_ready = 1'b0;
    redirect  = 1'b0;
    rst       = 1'b1;
    #1;
    chk({tag, ".rst_valid"}, 64'(out_valid), 64'd0);
    chk({tag, ".rst_pc"}, pc, RESET_PC);
    chk({tag, ".rst_mis"}, 64'(misaligned), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    m_pc  = RESET_PC;
    m_mis = 1'b0;
    compare_all({tag, ".post"});
  endtask

  initial begin
    logic [63:0] t;
    q.delete();
    m_pc  = RESET_PC;
    m_mis = 1'b0;
    @(negedge clk);
    do_reset("init");

    for (int i = 0; i < 4; i++) step("seq", 1'b1, 1'b0, 64'd0);

    do_reset("bp");
    for (int i = 0; i < 5; i++) step("stall", 1'b0, 1'b0, 64'd0);
    chk("bp.hold_pc", pc, 64'd16);
    for (int i = 0; i < 5; i++) step("drain", 1'b1, 1'b0, 64'd0);

    for (int i = 0; i < 3; i++) step("fill", 1'b0, 1'b0, 64'd0);
    step("redir", 1'b1, 1'b1, 64'h40);
    chk("redir.pc", pc, 64'h40);
    chk("redir.valid", 64'(out_valid), 64'd0);
    step("redir1", 1'b1, 1'b0, 64'd0);
    chk("redir1.out_pc", out_pc, 64'h40);

    for (int i = 0; i < 3; i++) step("fill2", 1'b0, 1'b0, 64'd0);
    do_reset("mid");

    step("mis", 1'b1, 1'b1, 64'h44);
    for (int i = 0; i < 3; i++) step("mis_run", 1'b1, 1'b0, 64'd0);
    do_reset("mis_clr");

    step("wrap", 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8);
    step("wrap1", 1'b1, 1'b0, 64'd0);
    chk("wrap.next_pc", pc, 64'd0);
    for (int i = 0; i < 3; i++) step("wrap_run", 1'b1, 1'b0, 64'd0);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        do_reset("rnd_rst");
      end else if ($urandom_range(0, 7) == 0) begin
        t = {$urandom, $urandom};
        if ($urandom_range(0, 3) != 0) t = t - (t % 8);
        step("rnd_red", 1'($urandom_range(0, 1)), 1'b1, t);
      end else begin
        step("rnd", 1'($urandom_range(0, 3) != 0), 1'b0, 64'd0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
